// File: rtl/number_adder_timer.sv
// Ripple-carry adder of full-adder cells next to an independent LED divider.
// Define TIMER_SIM_FAST_EN to force the divider to 4 cycles per half-period.
module number_adder_timer #(
    parameter int WIDTH     = 32,
    parameter int DIV_COUNT = 25_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             led
);

`ifdef TIMER_SIM_FAST_EN
    localparam int EFF_DIV = 4;
`else
    localparam int EFF_DIV = DIV_COUNT;
`endif

    localparam int CW = (EFF_DIV > 1) ? $clog2(EFF_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(EFF_DIV - 1);

    logic [WIDTH:0] carry;
    logic [CW-1:0]  count;

    assign carry[0] = cin;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_fa
            assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = carry[WIDTH];

    // Wrap and toggle happen together, so count never passes LAST.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
            led   <= 1'b0;
        end else if (count == LAST) begin
            count <= '0;
            led   <= ~led;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: tb/tb_number_adder_timer.sv
// Bench for number_adder_timer: directed and random adder checks at three
// widths, plus LED timing against an edge-count model across resets.
module tb_number_adder_timer;

`ifdef TIMER_SIM_FAST_EN
    localparam int MAIN_DIV = 25_000_000;
    localparam int EFF_MAIN = 4;
    localparam int EFF_ONE  = 4;
`else
    localparam int MAIN_DIV = 4;
    localparam int EFF_MAIN = 4;
    localparam int EFF_ONE  = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] a32, b32, sum32;
    logic [7:0]  a8, b8, sum8;
    logic [0:0]  a1, b1, sum1;
    logic        cin32, cin8, cin1;
    logic        cout32, cout8, cout1;
    logic        led32, led8, led1;

    int pass_cnt = 0;
    int total = 0;

    always #5 clk = ~clk;

    number_adder_timer #(.WIDTH(32), .DIV_COUNT(MAIN_DIV)) u32 (
        .clk(clk), .rst_n(rst_n), .a(a32), .b(b32), .cin(cin32),
        .sum(sum32), .cout(cout32), .led(led32)
    );
    number_adder_timer #(.WIDTH(8), .DIV_COUNT(1)) u8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cin(cin8),
        .sum(sum8), .cout(cout8), .led(led8)
    );
    number_adder_timer #(.WIDTH(1), .DIV_COUNT(1)) u1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .cin(cin1),
        .sum(sum1), .cout(cout1), .led(led1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // led after n enabled edges since release: toggles once every d edges
    function automatic logic exp_led(input int n, input int d);
        return 1'((n / d) % 2);
    endfunction

    task automatic add32(input logic [31:0] x, input logic [31:0] y, input logic c, input string tag);
        logic [32:0] m;
        a32 = x; b32 = y; cin32 = c;
        #1;
        m = 33'(x) + 33'(y) + 33'(c);
        check(tag, {31'd0, cout32, sum32}, {31'd0, m});
    endtask

    task automatic rand_adders(input string tag);
        logic [8:0] m8;
        logic [1:0] m1;
        add32($urandom, $urandom, 1'($urandom_range(0, 1)), {tag, "_w32"});
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom_range(0, 1));
        a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom_range(0, 1));
        #1;
        m8 = 9'(a8) + 9'(b8) + 9'(cin8);
        m1 = 2'(a1) + 2'(b1) + 2'(cin1);
        check({tag, "_w8"}, {55'd0, cout8, sum8}, {55'd0, m8});
        check({tag, "_w1"}, {62'd0, cout1, sum1}, {62'd0, m1});
    endtask

    // Runs n enabled edges, checking both LED rates and the adders each edge.
    task automatic run_timer(input int n, input string tag);
        for (int i = 1; i <= n; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_led_main"}, {63'd0, led32}, {63'd0, exp_led(i, EFF_MAIN)});
            check({tag, "_led_one"}, {63'd0, led8}, {63'd0, exp_led(i, EFF_ONE)});
            check({tag, "_led_w1"}, {63'd0, led1}, {63'd0, exp_led(i, EFF_ONE)});
            rand_adders({tag, "_add"});
        end
    endtask

    initial begin
        a32 = '0; b32 = '0; cin32 = 1'b0;
        a8 = '0; b8 = '0; cin8 = 1'b0;
        a1 = '0; b1 = '0; cin1 = 1'b0;

        // Directed adder vectors applied while reset is held
        add32(32'h0000_0001, 32'h0000_0002, 1'b0, "basic_1_2");
        add32(32'h1234_5678, 32'h1111_2222, 1'b0, "basic_pattern");
        add32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "allones_plus1");
        add32(32'h8000_0000, 32'h8000_0000, 1'b0, "msb_carry");
        add32(32'hAAAA_AAAA, 32'h5555_5555, 1'b0, "chain_cin0");
        add32(32'hAAAA_AAAA, 32'h5555_5555, 1'b1, "chain_cin1");
        add32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, "to_msb");
        add32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "allones_cin1");
        check("basic_exact", {32'd0, sum32}, 64'hFFFF_FFFF);

        repeat (2) @(posedge clk);
        #1;
        check("reset_led_main", {63'd0, led32}, 64'd0);
        check("reset_led_one", {63'd0, led8}, 64'd0);
        check("reset_led_w1", {63'd0, led1}, 64'd0);

        @(negedge clk);
        rst_n = 1'b1;
        run_timer(20, "period");

        // Reset lands mid-count on the sixth edge of a fresh run
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("reset_led_main", {63'd0, led32}, 64'd0);
        check("reset_led_one", {63'd0, led8}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_timer(5, "pre_mid");
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midreset_led_main", {63'd0, led32}, 64'd0);
        check("midreset_led_one", {63'd0, led8}, 64'd0);
        check("midreset_led_w1", {63'd0, led1}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_timer(12, "post_mid");

        for (int i = 0; i < 10000; i++) rand_adders("rand");

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/number_adder_timer.md
NUMBER_ADDER_TIMER -- requirements
Module: number_adder_timer

Interface
REQ-001 Parameter WIDTH, 32: operand and sum width in bits; legal range 1..64.
REQ-002 Parameter DIV_COUNT, 25_000_000: clk cycles per led half-period; minimum 1; gives 1 Hz led at 50 MHz clk.
REQ-003 Port clk  input  1: single clock; every register is clocked on its rising edge.
REQ-004 Port rst_n  input  1: synchronous reset, active-low, sampled on the rising edge of clk.
REQ-005 Port a  input  WIDTH: addend A.
REQ-006 Port b  input  WIDTH: addend B.
REQ-007 Port cin  input  1: carry-in.
REQ-008 Port sum  output  WIDTH: low WIDTH bits of a+b+cin.
REQ-009 Port cout  output  1: carry-out, bit WIDTH of a+b+cin.
REQ-010 Port led  output  1: divided square wave, registered; drives LEDs and serves as a slow clock for consumers.

Function
REQ-011 The adder path SHALL be purely combinational: zero latency, no dependence on clk or rst_n.
REQ-012 The adder path SHALL satisfy {cout,sum} = a + b + cin exactly, as a (WIDTH+1)-bit result, for all inputs.
REQ-013 The adder path SHALL be built as a chain of 1-bit full-adder cells, sum_i = a_i^b_i^c_i and c_(i+1) = a_i&b_i | c_i&(a_i^b_i), with c_0 = cin and cout = c_WIDTH.
REQ-014 Boundary: all-ones + 1 with cin=0 SHALL give sum=0, cout=1.
REQ-015 Boundary: all-ones + all-ones with cin=1 SHALL give sum=all-ones, cout=1.
REQ-016 Timer counter width SHALL be max(1, ceil(log2(DIV_COUNT))) bits.
REQ-017 Timer: each clk edge with rst_n=1, if count == DIV_COUNT-1 then count <= 0 and led <= ~led; otherwise count <= count+1.
REQ-018 led SHALL therefore have period 2*DIV_COUNT clk cycles with a 50% duty cycle.
REQ-019 The first led toggle after reset release SHALL occur on the DIV_COUNT-th rising edge of clk with rst_n=1.
REQ-020 With DIV_COUNT=1, led SHALL toggle on every rising edge of clk.
REQ-021 The counter SHALL never exceed DIV_COUNT-1; wrap-around to 0 coincides with the toggle.
REQ-022 The adder and the timer SHALL be fully independent; adder inputs never affect led.

Reset
REQ-023 While rst_n=0 at a rising edge of clk, the timer SHALL load count=0 and led=0.
REQ-024 Reset asserted mid-count SHALL discard the partial count; the period restarts from REQ-019 after release.
REQ-025 Before the first clk edge with rst_n=0, led is undefined; sum and cout are always valid from the inputs.
REQ-026 rst_n SHALL have no effect on sum or cout.

Configuration
REQ-027 Macro TIMER_SIM_FAST_EN defined: the effective divide count SHALL be 4, regardless of DIV_COUNT, so led toggles every 4 clk cycles (period 8).
REQ-028 Macro TIMER_SIM_FAST_EN undefined: the effective divide count SHALL be DIV_COUNT.
REQ-029 The macro SHALL NOT change the port list or the adder behaviour.

Verification
REQ-030 Adder basic: a=0x00000001, b=0x00000002, cin=0 -> sum=0x00000003, cout=0; a=0x12345678, b=0x11112222, cin=0 -> sum=0x2345789A, cout=0.
REQ-031 Adder carry-out: a=0xFFFFFFFF, b=0x00000001, cin=0 -> sum=0, cout=1; a=0x80000000, b=0x80000000, cin=0 -> sum=0, cout=1.
REQ-032 Adder carry chain: a=0xAAAAAAAA, b=0x55555555 -> cin=0 gives sum=0xFFFFFFFF, cout=0; cin=1 gives sum=0x00000000, cout=1; a=0x7FFFFFFF, b=1, cin=0 -> sum=0x80000000, cout=0.
REQ-033 Adder random: at least 10000 random a, b, cin compared against a (WIDTH+1)-bit model sum, also run with WIDTH=8 and WIDTH=1.
REQ-034 Timer period, DIV_COUNT=4: release reset -> led=0 for edges 1-3, led rises at edge 4, falls at edge 8, repeats with period 8.
REQ-035 Timer reset mid-count, DIV_COUNT=4: assert rst_n=0 at edge 6 -> led=0 and count=0 next edge; after release the first toggle comes 4 edges later; repeat the check with TIMER_SIM_FAST_EN defined and DIV_COUNT=25_000_000.
